coin_input_cond: RTL
====================

// Module: coin_input_cond
// PURPOSE
//   Upstream front end for the cola vending FSM. Conditions two raw, asynchronous,
//   active-low coin switches (1-yuan, 0.5-yuan): synchronises and debounces each one.
//   Emits exactly one single-cycle pulse per accepted coin on pi_money_one / pi_money_half.
//   Guarantees the two pulses are never high in the same cycle, so the downstream
//   FSM never sees pi_money == 2'b11.
// PARAMETERS
//   CNT_MAX   20'd999_999   debounce length in sys_clk cycles (20 ms @ 50 MHz); legal range >= 2
//   CNT_W     20            counter width; must satisfy 2**CNT_W > CNT_MAX
// PORTS
//   sys_clk        in   1  system clock, all logic on posedge
//   sys_rst_n      in   1  asynchronous active-low reset
//   key_one_n      in   1  raw 1-yuan coin switch, active-low, asynchronous, bouncy
//   key_half_n     in   1  raw 0.5-yuan coin switch, active-low, asynchronous, bouncy
//   pi_money_one   out  1  registered 1-cycle pulse: one 1-yuan coin accepted
//   pi_money_half  out  1  registered 1-cycle pulse: one 0.5-yuan coin accepted
// BEHAVIOUR
//   Reset
//   - Async, active-low. Sync flops -> 1 (released). Both FSMs -> IDLE.
//   - Counters -> 0, half_pend -> 0, both outputs -> 0.
//   - Reset mid-debounce discards the partial count; no pulse is emitted.
//   - A key held low through reset release is treated as a new press and yields one
//     pulse after full debounce.
//   Synchroniser
//   - 2-flop synchroniser per key; only its 2nd-stage output (s_n) is used below.
//   Per-channel FSM (identical for ONE and HALF), with an independent CNT_W-bit counter
//   - IDLE:         s_n==0 -> PRESS_WAIT, cnt<=0; else stay.
//   - PRESS_WAIT:   s_n==1 -> IDLE, cnt<=0 (bounce rejected).
//                   s_n==0 and cnt==CNT_MAX-1 -> PRESSED, raise qualify event.
//                   else cnt<=cnt+1.
//   - PRESSED:      s_n==1 -> RELEASE_WAIT, cnt<=0; else stay. Holding the key does not repeat.
//   - RELEASE_WAIT: s_n==0 -> PRESSED, cnt<=0 (release bounce; no new pulse).
//                   s_n==1 and cnt==CNT_MAX-1 -> IDLE.
//                   else cnt<=cnt+1.
//   - Illegal state -> IDLE, cnt<=0.
//   - The counter never wraps: it is cleared on every state change and stops at CNT_MAX-1.
//   Latency
//   - Raw key stable low first sampled at clock edge e1 -> pulse high for exactly the
//     cycle after edge e(CNT_MAX+3).
//   - Minimum accepted press width: CNT_MAX+1 cycles of stable low at s_n.
//   Output arbitration
//   - Qualify on ONE only: pi_money_one<=1 at that edge.
//   - Qualify on HALF only: pi_money_half<=1, unless ONE is pulsing the same edge.
//   - Simultaneous qualify on both: pi_money_one<=1 and half_pend<=1. At the next edge,
//     pi_money_half<=1 and half_pend<=0.
//   - Both outputs are otherwise 0 and are never 1 in the same cycle.
//   - No coin is ever lost: one accepted press gives exactly one pulse.
// TESTING  (sim with CNT_MAX=4)
//   1. key_one_n low 20 cycles, then high -> exactly one pi_money_one pulse, high for the
//      cycle after edge 7; pi_money_half stays 0.
//   2. key_half_n toggles low/high every 2 cycles for 30 cycles, then low 10 cycles ->
//      no pulse during toggling; exactly one pi_money_half pulse after the stable low.
//   3. Both keys driven low on the same edge and held 15 cycles -> pi_money_one pulses
//      after edge 7, pi_money_half after edge 8; never both high together.
//   4. key_one_n held low 100 cycles with 1-cycle high glitches at cycles 20 and 50 ->
//      single pi_money_one pulse; release + 6 stable-high cycles + re-press -> second pulse.
//   5. key_one_n low; assert sys_rst_n=0 at edge 5 for 3 cycles -> outputs 0 immediately,
//      no pulse before reset. After release with key still low -> one pulse CNT_MAX+3
//      edges later.
//   6. Feed the outputs into the vending FSM; press 1-yuan twice -> po_cola=1 and
//      po_money=1 one cycle after the second pulse.

Source files
------------

// File: rtl/coin_input_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_input_cond_if
// Description : Coin switch inputs and accepted-coin pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_input_cond_if;
    logic key_one_n;
    logic key_half_n;
    logic pi_money_one;
    logic pi_money_half;

    modport master (
        output key_one_n,
        output key_half_n,
        input  pi_money_one,
        input  pi_money_half
    );

    modport slave (
        input  key_one_n,
        input  key_half_n,
        output pi_money_one,
        output pi_money_half
    );
endinterface
`default_nettype wire

// File: rtl/coin_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : coin_input_cond
// Description : Synchronises and debounces two coin switches and emits one
//               non-overlapping single-cycle pulse per accepted coin.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_input_cond #(
    parameter int unsigned      CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    coin_input_cond_if.slave  coin
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_MAX - 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0] w_key_n;
    logic [1:0] w_qual;
    logic       r_money_one;
    logic       r_money_half;
    logic       r_half_pend;

    // Channel 0 is the 1-yuan switch, channel 1 the 0.5-yuan switch.
    assign w_key_n = {coin.key_half_n, coin.key_one_n};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_sync1;
            logic             r_sync2;
            logic             w_hit;
            logic             w_qual_ch;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_n[g];
                    r_sync2 <= r_sync1;
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            assign w_hit = (r_cnt == c_cnt_last);

            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_qual_ch   = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (!r_sync2) begin
                            w_state_nxt = ST_PRESS_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (r_sync2) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (w_hit) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                            w_qual_ch   = 1'b1;
                        end else begin
                            w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (r_sync2) begin
                            w_state_nxt = ST_RELEASE_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        // A low during release debounce is bounce, not a new coin.
                        if (!r_sync2) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else if (w_hit) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            assign w_qual[g] = w_qual_ch;
        end
    endgenerate

    // A half coin that qualifies together with a one coin is deferred a cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_money_one  <= 1'b0;
            r_money_half <= 1'b0;
            r_half_pend  <= 1'b0;
        end else begin
            r_money_one  <= w_qual[0];
            r_money_half <= (w_qual[1] & ~w_qual[0]) | r_half_pend;
            r_half_pend  <= w_qual[1] & w_qual[0];
        end
    end

    assign coin.pi_money_one  = r_money_one;
    assign coin.pi_money_half = r_money_half;

endmodule
`default_nettype wire
